// File: rtl/uart_cmd_dispatch.sv
// rtl/uart_cmd_dispatch.sv - UART byte command sequencer for the stopwatch and calculator cores
//
// Purpose:
//   Consumes bytes from the UART receiver. Single-byte stopwatch commands
//   ('S', 'P', 'R') become one-cycle control pulses. A calculator command of
//   the form "C<A><op><B>=" is parsed into two binary operands and an opcode,
//   then presented to the calculator with a req/ack handshake. Malformed
//   input, overlong operands and inter-byte silence inside a calculator
//   command raise a one-cycle error pulse with a sticky cause code.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_rx_data    received byte, qualified by i_rx_valid
//   i_rx_valid   one-cycle strobe for i_rx_data
//   i_calc_ack   calculator accepted the request (level)
//   o_sw_start   one-cycle stopwatch start pulse
//   o_sw_stop    one-cycle stopwatch stop pulse
//   o_sw_clear   one-cycle stopwatch clear pulse
//   o_calc_a     operand A (binary)
//   o_calc_b     operand B (binary)
//   o_calc_op    opcode: 0 '+', 1 '-', 2 '*', 3 '/'
//   o_calc_req   request to the calculator, held until ack
//   o_err        one-cycle error pulse
//   o_err_code   cause of last error: 1 bad char, 2 too many digits, 3 timeout
//   o_busy       high whenever a command is in progress
module uart_cmd_dispatch #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_MS = 1000,
  parameter int MAX_DIGITS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_calc_ack,
  output logic        o_sw_start,
  output logic        o_sw_stop,
  output logic        o_sw_clear,
  output logic [13:0] o_calc_a,
  output logic [13:0] o_calc_b,
  output logic [1:0]  o_calc_op,
  output logic        o_calc_req,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  localparam logic [31:0] TIMEOUT_CYCLES = 32'((CLK_FREQ / 1000) * TIMEOUT_MS);
  localparam logic [31:0] TIMEOUT_LAST   = TIMEOUT_CYCLES - 32'd1;
  localparam int          DW             = $clog2(MAX_DIGITS + 1);
  localparam logic [DW-1:0] DIGITS_MAX   = DW'(MAX_DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPA,
    ST_OPB,
    ST_ISSUE
  } state_t;

  state_t          r_state, w_state_n;
  logic [13:0]     r_a, w_a_n;
  logic [13:0]     r_b, w_b_n;
  logic [1:0]      r_op, w_op_n;
  logic [DW-1:0]   r_nd, w_nd_n;
  logic [31:0]     r_tmo, w_tmo_n;
  logic            r_start, w_start_n;
  logic            r_stop, w_stop_n;
  logic            r_clear, w_clear_n;
  logic            r_err, w_err_n;
  logic [1:0]      r_code, w_code_n;
  logic            r_req, w_req_n;

  logic            w_is_digit;
  logic [3:0]      w_digit;
  logic [13:0]     w_acc;
  logic [13:0]     w_acc_next;
  logic            w_is_op;
  logic [1:0]      w_op_dec;
  logic [31:0]     w_tmo_inc;

  assign w_is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
  assign w_digit    = i_rx_data[3:0];
  assign w_acc      = (r_state == ST_OPB) ? r_b : r_a;
  // Multiply-accumulate in 17 bits, then keep the low 14 bits.
  assign w_acc_next = 14'(({3'b000, w_acc} * 17'd10) + {13'd0, w_digit});
  assign w_tmo_inc  = r_tmo + 32'd1;

  always_comb begin
    w_is_op  = 1'b1;
    w_op_dec = 2'd0;
    case (i_rx_data)
      8'h2B:   w_op_dec = 2'd0;
      8'h2D:   w_op_dec = 2'd1;
      8'h2A:   w_op_dec = 2'd2;
      8'h2F:   w_op_dec = 2'd3;
      default: w_is_op  = 1'b0;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_op_n    = r_op;
    w_nd_n    = r_nd;
    w_tmo_n   = r_tmo;
    w_start_n = 1'b0;
    w_stop_n  = 1'b0;
    w_clear_n = 1'b0;
    w_err_n   = 1'b0;
    w_code_n  = r_code;
    w_req_n   = r_req;

    case (r_state)
      ST_IDLE: begin
        w_tmo_n = '0;
        if (i_rx_valid) begin
          case (i_rx_data)
            8'h53: w_start_n = 1'b1;
            8'h50: w_stop_n  = 1'b1;
            8'h52: w_clear_n = 1'b1;
            8'h43: begin
              w_a_n     = '0;
              w_b_n     = '0;
              w_nd_n    = '0;
              w_state_n = ST_OPA;
            end
            8'h0D, 8'h0A, 8'h20: ;
            default: begin
              w_err_n  = 1'b1;
              w_code_n = 2'd1;
            end
          endcase
        end
      end

      ST_OPA, ST_OPB: begin
        if (i_rx_valid) begin
          // A byte always restarts the silence counter, even on the expiry cycle.
          w_tmo_n = '0;
          if (w_is_digit) begin
            if (r_nd == DIGITS_MAX) begin
              w_err_n   = 1'b1;
              w_code_n  = 2'd2;
              w_state_n = ST_IDLE;
            end else begin
              if (r_state == ST_OPA) begin
                w_a_n = w_acc_next;
              end else begin
                w_b_n = w_acc_next;
              end
              w_nd_n = r_nd + DW'(1);
            end
          end else if ((r_state == ST_OPA) && w_is_op) begin
            if (r_nd != '0) begin
              w_op_n    = w_op_dec;
              w_nd_n    = '0;
              w_state_n = ST_OPB;
            end else begin
              w_err_n   = 1'b1;
              w_code_n  = 2'd1;
              w_state_n = ST_IDLE;
            end
          end else if ((r_state == ST_OPB) && (i_rx_data == 8'h3D)) begin
            if (r_nd != '0) begin
              w_state_n = ST_ISSUE;
              w_req_n   = 1'b1;
            end else begin
              w_err_n   = 1'b1;
              w_code_n  = 2'd1;
              w_state_n = ST_IDLE;
            end
          end else if (i_rx_data == 8'h1B) begin
            w_state_n = ST_IDLE;
          end else begin
            w_err_n   = 1'b1;
            w_code_n  = 2'd1;
            w_state_n = ST_IDLE;
          end
        end else if (w_tmo_inc == TIMEOUT_LAST) begin
          w_err_n   = 1'b1;
          w_code_n  = 2'd3;
          w_state_n = ST_IDLE;
          w_tmo_n   = '0;
        end else begin
          w_tmo_n = w_tmo_inc;
        end
      end

      ST_ISSUE: begin
        w_tmo_n = '0;
        // Bytes are rejected while the request is outstanding; ack still completes it.
        if (i_rx_valid) begin
          w_err_n  = 1'b1;
          w_code_n = 2'd1;
        end
        if (i_calc_ack) begin
          w_req_n   = 1'b0;
          w_state_n = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_nd    <= '0;
      r_tmo   <= '0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_clear <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_op    <= w_op_n;
      r_nd    <= w_nd_n;
      r_tmo   <= w_tmo_n;
      r_start <= w_start_n;
      r_stop  <= w_stop_n;
      r_clear <= w_clear_n;
      r_err   <= w_err_n;
      r_code  <= w_code_n;
      r_req   <= w_req_n;
    end
  end

  assign o_sw_start = r_start;
  assign o_sw_stop  = r_stop;
  assign o_sw_clear = r_clear;
  assign o_calc_a   = r_a;
  assign o_calc_b   = r_b;
  assign o_calc_op  = r_op;
  assign o_calc_req = r_req;
  assign o_err      = r_err;
  assign o_err_code = r_code;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// tb/tb_uart_cmd_dispatch.sv - self-checking bench for uart_cmd_dispatch against a byte-level reference model
module tb_uart_cmd_dispatch;

  localparam int TMO  = 5;
  localparam int MAXD = 4;
  localparam int M_IDLE  = 0;
  localparam int M_A     = 1;
  localparam int M_B     = 2;
  localparam int M_ISSUE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        calc_ack;
  logic        sw_start, sw_stop, sw_clear;
  logic [13:0] calc_a, calc_b;
  logic [1:0]  calc_op;
  logic        calc_req, err;
  logic [1:0]  err_code;
  logic        busy;

  uart_cmd_dispatch #(
    .CLK_FREQ   (1000),
    .TIMEOUT_MS (TMO),
    .MAX_DIGITS (MAXD)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .i_calc_ack (calc_ack),
    .o_sw_start (sw_start),
    .o_sw_stop  (sw_stop),
    .o_sw_clear (sw_clear),
    .o_calc_a   (calc_a),
    .o_calc_b   (calc_b),
    .o_calc_op  (calc_op),
    .o_calc_req (calc_req),
    .o_err      (err),
    .o_err_code (err_code),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  string phase       = "init";

  // Reference model: command mode, operand values, digits typed, quiet cycles.
  int   m_mode, m_a, m_b, m_op, m_nd, m_quiet, m_code;
  bit   e_start, e_stop, e_clear, e_err, e_req;
  int   ack_dly;
  logic [3:0] req_hist;
  int   req_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s (%s): got %0h expected %0h", tag, phase, got, exp);
    end
  endtask

  function automatic logic [37:0] act_vec();
    return {sw_start, sw_stop, sw_clear, err, err_code, calc_req, busy, calc_op, calc_b, calc_a};
  endfunction

  function automatic logic [37:0] exp_vec();
    return {e_start, e_stop, e_clear, e_err, 2'(m_code), e_req, (m_mode != M_IDLE),
            2'(m_op), 14'(m_b), 14'(m_a)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_a = 0; m_b = 0; m_op = 0; m_nd = 0; m_quiet = 0; m_code = 0;
    e_start = 0; e_stop = 0; e_clear = 0; e_err = 0; e_req = 0;
    req_hist = '0;
  endtask

  task automatic raise(input int code);
    e_err  = 1;
    m_code = code;
  endtask

  task automatic model(input bit v, input logic [7:0] d, input bit ack);
    int dig;
    e_start = 0; e_stop = 0; e_clear = 0; e_err = 0;
    if (m_mode == M_ISSUE) begin
      if (v) raise(1);
      if (ack) begin
        e_req  = 0;
        m_mode = M_IDLE;
      end
    end else if (v) begin
      m_quiet = 0;
      if (m_mode == M_IDLE) begin
        if (d == "S") e_start = 1;
        else if (d == "P") e_stop = 1;
        else if (d == "R") e_clear = 1;
        else if (d == "C") begin
          m_a = 0; m_b = 0; m_nd = 0; m_mode = M_A;
        end else if (d == 8'h0D || d == 8'h0A || d == " ") begin
        end else raise(1);
      end else if (d >= "0" && d <= "9") begin
        if (m_nd == MAXD) begin
          raise(2); m_mode = M_IDLE;
        end else begin
          dig = d - "0";
          if (m_mode == M_A) m_a = (m_a * 10 + dig) % 16384;
          else               m_b = (m_b * 10 + dig) % 16384;
          m_nd++;
        end
      end else if (m_mode == M_A && (d == "+" || d == "-" || d == "*" || d == "/")) begin
        if (m_nd == 0) begin
          raise(1); m_mode = M_IDLE;
        end else begin
          m_op   = (d == "+") ? 0 : (d == "-") ? 1 : (d == "*") ? 2 : 3;
          m_nd   = 0;
          m_mode = M_B;
        end
      end else if (m_mode == M_B && d == "=") begin
        if (m_nd == 0) begin
          raise(1); m_mode = M_IDLE;
        end else begin
          m_mode = M_ISSUE;
          e_req  = 1;
        end
      end else if (d == 8'h1B) begin
        m_mode = M_IDLE;
      end else begin
        raise(1); m_mode = M_IDLE;
      end
    end else if (m_mode == M_A || m_mode == M_B) begin
      m_quiet++;
      if (m_quiet == TMO - 1) begin
        raise(3); m_mode = M_IDLE;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs after the edge.
  task automatic step(input bit v, input logic [7:0] d);
    bit ack;
    ack      = (ack_dly == 0) ? e_req : req_hist[ack_dly - 1];
    rx_valid = v;
    rx_data  = v ? d : 8'($urandom);
    calc_ack = ack;
    req_hist = {req_hist[2:0], e_req};
    model(v, d, ack);
    @(posedge clk);
    #1;
    if (calc_req) req_cycles++;
    check("outputs", act_vec(), exp_vec());
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i]);
      idle(gap);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int k;
    k = $urandom_range(0, 99);
    if (k < 40) return 8'(8'h30 + $urandom_range(0, 9));
    if (k < 50) begin
      case ($urandom_range(0, 3))
        0:       return "+";
        1:       return "-";
        2:       return "*";
        default: return "/";
      endcase
    end
    if (k < 58) return "=";
    if (k < 68) return "C";
    if (k < 76) begin
      case ($urandom_range(0, 2))
        0:       return "S";
        1:       return "P";
        default: return "R";
      endcase
    end
    if (k < 82) begin
      case ($urandom_range(0, 3))
        0:       return 8'h1B;
        1:       return 8'h0D;
        2:       return 8'h0A;
        default: return 8'h20;
      endcase
    end
    return 8'($urandom);
  endfunction

  initial begin
    int n;
    int gap;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; calc_ack = 1'b0;
    ack_dly = 0; req_cycles = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    check("reset_state", act_vec(), exp_vec());
    rst = 1'b0;

    phase = "stopwatch";
    send_str("SPR", 1);
    idle(2);

    phase = "calc_basic";
    ack_dly = 3; req_cycles = 0;
    send_str("C12+345=", 0);
    idle(6);
    check("t2_a", calc_a, 12);
    check("t2_b", calc_b, 345);
    check("t2_op", calc_op, 0);
    check("t2_req_len", req_cycles, 4);
    check("t2_busy", busy, 0);

    phase = "calc_max";
    ack_dly = 1;
    send_str("C9999*7=", 0);
    idle(4);
    check("t3_a", calc_a, 9999);
    check("t3_b", calc_b, 7);
    check("t3_op", calc_op, 2);
    send_str("C8/2=", 1);
    idle(4);
    check("t3_a2", calc_a, 8);
    check("t3_b2", calc_b, 2);
    check("t3_op2", calc_op, 3);

    phase = "ack_on_entry";
    ack_dly = 0; req_cycles = 0;
    send_str("C5-6=", 0);
    idle(3);
    check("t3_req_len1", req_cycles, 1);

    phase = "too_many_digits";
    send_str("C1234", 0);
    step(1'b1, "5");
    check("t4_err", err, 1);
    check("t4_code", err_code, 2);
    check("t4_busy", busy, 0);
    step(1'b1, "S");
    check("t4_start", sw_start, 1);

    phase = "timeout";
    send_str("C1", 0);
    n = 1;
    while (!err && n < 10) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("t5_latency", n, 5);
    check("t5_code", err_code, 3);
    send_str("C1", 0);
    idle(3);
    step(1'b1, "2");
    check("t5_race_err", err, 0);
    check("t5_race_busy", busy, 1);
    idle(3);
    check("t5_still_busy", busy, 1);
    step(1'b1, 8'h1B);

    phase = "bad_syntax";
    send_str("C+", 0);
    check("t6_op_first", {err, err_code}, 3'b101);
    idle(1);
    send_str("C1+=", 0);
    check("t6_empty_b", {err, err_code}, 3'b101);
    idle(1);
    send_str("X", 0);
    check("t6_bad_char", {err, err_code}, 3'b101);
    send_str("C12", 0);
    step(1'b1, 8'h1B);
    check("t6_esc", {err, busy}, 2'b00);

    phase = "reset_issue";
    ack_dly = 3;
    send_str("C1+2=", 0);
    step(1'b0, 8'h00);
    check("t6_req_before", calc_req, 1);
    rst = 1'b1;
    #1;
    check("t6_req_dropped", {calc_req, busy}, 2'b00);
    check("t6_a_cleared", calc_a, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      ack_dly = $urandom_range(0, 3);
      step(1'b1, rand_byte());
      gap = ($urandom_range(0, 9) < 6) ? $urandom_range(0, 1) : $urandom_range(2, 5);
      idle(gap);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
